// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: LC-3b MEM-stage sequencer for word, byte and indirect loads/stores.
// Runs the memory handshake, stalls the pipeline, and returns aligned load data.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] src_data,
    output logic        stall,
    output logic        done,
    output logic [15:0] load_data,
    output logic        err,
    output logic [15:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int unsigned WAIT_W = 16;

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam logic              TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PTR_RD = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic is_read(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_write(input logic [3:0] op);
        return (op == OP_STB) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       src_q, src_d;
    logic [15:0]       ptr_q, ptr_d;
    logic [15:0]       load_q, load_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic              access_c;
    logic              timeout_c;
    logic [7:0]        lane_c;
    logic [15:0]       rdata_fmt_c;

    assign access_c  = req_valid && (is_read(opcode) || is_write(opcode));
    assign timeout_c = TIMEOUT_EN && (wait_q == WAIT_LAST);

    // Load formatting: byte loads pick the lane by address bit 0 and sign-extend.
    always_comb begin
        lane_c      = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        rdata_fmt_c = (op_q == OP_LDB) ? {{8{lane_c[7]}}, lane_c} : mem_rdata;
    end

    // Next-state logic: access sequencing, wait counter and result capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        stall   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    stall   = 1'b1;
                    op_d    = opcode;
                    addr_d  = addr;
                    src_d   = src_data;
                    wait_d  = '0;
                    state_d = is_indirect(opcode) ? S_PTR_RD : S_ACCESS;
                end
            end
            S_PTR_RD: begin
                stall = 1'b1;
                if (mem_resp) begin
                    ptr_d   = mem_rdata;
                    wait_d  = '0;
                    state_d = S_ACCESS;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_DONE;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (mem_resp) begin
                    if (is_read(op_q)) begin
                        load_d = rdata_fmt_c;
                    end
                    wait_d  = '0;
                    state_d = S_DONE;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_DONE;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                wait_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory interface decode from the registered state and access fields.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = {addr_q[15:1], 1'b0};
        mem_byte_enable = 2'b11;
        mem_wdata       = '0;

        case (state_q)
            S_PTR_RD: begin
                mem_read = 1'b1;
            end
            S_ACCESS: begin
                if (is_indirect(op_q)) begin
                    mem_address = {ptr_q[15:1], 1'b0};
                end
                if (is_write(op_q)) begin
                    mem_write = 1'b1;
                    if (op_q == OP_STB) begin
                        mem_wdata       = {src_q[7:0], src_q[7:0]};
                        mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    end else begin
                        mem_wdata = src_q;
                    end
                end else begin
                    mem_read = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign load_data = load_q;

    // State and access-field registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            load_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized checks of mem_stage_ctrl against a
// transaction-level model; the bench plays the memory and predicts every cycle.
module tb_mem_stage_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [15:0] src_data;
    logic        stall;
    logic        done;
    logic [15:0] load_data;
    logic        err;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_load;

    logic [3:0] acc_ops [6]     = '{4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
    logic [3:0] nonacc_ops [10] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000,
                                    4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    always #5 clk = ~clk;

    mem_stage_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .opcode          (opcode),
        .addr            (addr),
        .src_data        (src_data),
        .stall           (stall),
        .done            (done),
        .load_data       (load_data),
        .err             (err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%04h expected=0x%04h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One full access: the bench acts as memory, responding after lat_p/lat_a wait cycles.
    task automatic do_access(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s,
                             input int lat_p, input int lat_a,
                             input logic [15:0] rd_p, input logic [15:0] rd_a, input bit flush);
        bit          wr;
        bit          ind;
        bit          timed;
        bit          fin;
        int          k;
        int          lat;
        logic [15:0] ptr;
        logic [15:0] exp_a;
        logic [15:0] exp_wd;
        logic [1:0]  exp_be;
        logic        exp_rd;
        logic        exp_wr;
        logic [7:0]  lane;

        wr    = (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
        ind   = (op == 4'b1010) || (op == 4'b1011);
        timed = 1'b0;
        ptr   = 16'h0000;

        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        src_data  = s;
        mem_resp  = 1'b0;
        mem_rdata = 16'($urandom);
        @(negedge clk);
        check("idle_stall", 16'(stall), 16'd1);
        check("idle_rd", 16'(mem_read), 16'd0);
        check("idle_wr", 16'(mem_write), 16'd0);
        check("idle_done", 16'(done), 16'd0);
        @(posedge clk);
        #1;
        if (flush) req_valid = 1'b0;

        for (int p = (ind ? 0 : 1); p < 2; p++) begin
            if (timed) break;
            lat    = (p == 0) ? lat_p : lat_a;
            exp_a  = (p == 1 && ind) ? {ptr[15:1], 1'b0} : {a[15:1], 1'b0};
            exp_rd = (p == 0) || !wr;
            exp_wr = (p == 1) && wr;
            if (p == 1 && op == 4'b0011) begin
                exp_be = a[0] ? 2'b10 : 2'b01;
                exp_wd = {s[7:0], s[7:0]};
            end else if (p == 1 && wr) begin
                exp_be = 2'b11;
                exp_wd = s;
            end else begin
                exp_be = 2'b11;
                exp_wd = 16'h0000;
            end
            fin = 1'b0;
            k   = 0;
            while (!fin) begin
                mem_resp  = (k == lat);
                mem_rdata = mem_resp ? ((p == 0) ? rd_p : rd_a) : 16'($urandom);
                @(negedge clk);
                check("acc_stall", 16'(stall), 16'd1);
                check("acc_done", 16'(done), 16'd0);
                check("acc_rd", 16'(mem_read), 16'(exp_rd));
                check("acc_wr", 16'(mem_write), 16'(exp_wr));
                check("acc_addr", mem_address, exp_a);
                check("acc_be", 16'(mem_byte_enable), 16'(exp_be));
                check("acc_wdata", mem_wdata, exp_wd);
                if (mem_resp) begin
                    fin = 1'b1;
                    if (p == 0) ptr = rd_p;
                end else if (k == MAXW - 1) begin
                    fin   = 1'b1;
                    timed = 1'b1;
                end
                k++;
                @(posedge clk);
                #1;
            end
        end

        if (!timed && !wr) begin
            if (op == 4'b0010) begin
                lane     = a[0] ? rd_a[15:8] : rd_a[7:0];
                exp_load = {{8{lane[7]}}, lane};
            end else begin
                exp_load = rd_a;
            end
        end

        mem_resp  = 1'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);
        check("done_pulse", 16'(done), 16'd1);
        check("done_err", 16'(err), 16'(timed));
        check("done_stall", 16'(stall), 16'd0);
        check("done_rd", 16'(mem_read), 16'd0);
        check("done_wr", 16'(mem_write), 16'd0);
        check("done_load", load_data, exp_load);
        @(posedge clk);
        #1;
        mem_resp  = 1'b0;
        req_valid = 1'b0;
    endtask

    // A cycle with no access request: nothing may move.
    task automatic idle_cycle();
        if ($urandom_range(0, 1) == 0) begin
            req_valid = 1'b1;
            opcode    = nonacc_ops[$urandom_range(0, 9)];
        end else begin
            req_valid = 1'b0;
            opcode    = 4'($urandom);
        end
        addr      = 16'($urandom);
        src_data  = 16'($urandom);
        mem_resp  = 1'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);
        check("nop_stall", 16'(stall), 16'd0);
        check("nop_rd", 16'(mem_read), 16'd0);
        check("nop_wr", 16'(mem_write), 16'd0);
        check("nop_done", 16'(done), 16'd0);
        check("nop_err", 16'(err), 16'd0);
        check("nop_load", load_data, exp_load);
        @(posedge clk);
        #1;
        mem_resp  = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        opcode    = 4'b0000;
        addr      = 16'h0000;
        src_data  = 16'h0000;
        mem_rdata = 16'h0000;
        mem_resp  = 1'b0;
        exp_load  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_rd", 16'(mem_read), 16'd0);
        check("rst_wr", 16'(mem_write), 16'd0);
        check("rst_load", load_data, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Word load with two wait cycles, address bit 0 dropped.
        do_access(4'b0110, 16'h3001, 16'h0000, 0, 2, 16'h0000, 16'hBEEF, 1'b0);
        check("ldr_value", load_data, 16'hBEEF);

        // Byte loads: high lane negative, low lane positive.
        do_access(4'b0010, 16'h2005, 16'h0000, 0, 0, 16'h0000, 16'h8012, 1'b0);
        check("ldb_hi", load_data, 16'hFF80);
        do_access(4'b0010, 16'h2004, 16'h0000, 0, 1, 16'h0000, 16'h8012, 1'b0);
        check("ldb_lo", load_data, 16'h0012);

        // Byte store to the high lane, word store, indirect store.
        do_access(4'b0011, 16'h4003, 16'h1234, 0, 0, 16'h0000, 16'h0000, 1'b0);
        do_access(4'b0111, 16'h4101, 16'hCAFE, 0, 1, 16'h0000, 16'h0000, 1'b0);
        do_access(4'b1011, 16'h5000, 16'hA5A5, 1, 1, 16'h6002, 16'h0000, 1'b0);
        check("sti_keeps_load", load_data, 16'h0012);

        // Indirect load, back-to-back, with a flush mid-access.
        do_access(4'b1010, 16'h7001, 16'h0000, 2, 0, 16'h1235, 16'h7777, 1'b1);

        // Timeout with no response, then a response on the final allowed cycle.
        do_access(4'b0110, 16'h3000, 16'h0000, 0, 99, 16'h0000, 16'h1111, 1'b0);
        check("timeout_load", load_data, 16'h7777);
        do_access(4'b0110, 16'h3002, 16'h0000, 0, MAXW - 1, 16'h0000, 16'h5A5A, 1'b0);
        idle_cycle();

        // Reset while an indirect load is fetching its pointer.
        req_valid = 1'b1;
        opcode    = 4'b1010;
        addr      = 16'h1234;
        src_data  = 16'h0000;
        mem_resp  = 1'b0;
        @(negedge clk);
        check("rstmid_idle_stall", 16'(stall), 16'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid_ptr_rd", 16'(mem_read), 16'd1);
        check("rstmid_ptr_addr", mem_address, 16'h1234);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        exp_load = 16'h0000;
        @(negedge clk);
        check("rstmid_rd", 16'(mem_read), 16'd0);
        check("rstmid_stall", 16'(stall), 16'd0);
        check("rstmid_load", load_data, 16'h0000);
        check("rstmid_done", 16'(done), 16'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        opcode    = 4'b0001;
        repeat (2) begin
            @(negedge clk);
            check("add_stall", 16'(stall), 16'd0);
            check("add_rd", 16'(mem_read), 16'd0);
            check("add_wr", 16'(mem_write), 16'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = acc_ops[$urandom_range(0, 5)];
            do_access(op, 16'($urandom), 16'($urandom),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
